// File: rtl/f56_bus_arbiter.sv
// Round-robin arbiter for the shared FALC56 PHY bus: registered one-hot grants,
// bounded hold time with timeout statistics, and a fixed turnaround gap between owners.
module f56_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int OWNER_W  = 2,
    parameter int MAX_HOLD = 64,
    parameter int TURN_CYC = 1,
    parameter int HOLD_W   = 16
) (
    input  logic               PHY_CLK33_I,
    input  logic               PHY_RSTn_I,
    input  logic               ENABLE_I,
    input  logic [N_REQ-1:0]   REQ_I,
    output logic [N_REQ-1:0]   GNT_O,
    output logic               BUS_BUSY_O,
    output logic [OWNER_W-1:0] OWNER_O,
    output logic               TIMEOUT_O,
    output logic [OWNER_W-1:0] TIMEOUT_ID_O,
    output logic [7:0]         TIMEOUT_CNT_O,
    input  logic               CLR_STATS_I
);

    localparam int TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [TURN_W-1:0]  TURN_LAST = TURN_W'(TURN_CYC - 1);
    localparam logic [OWNER_W:0]   N_REQ_EXT = (OWNER_W + 1)'(N_REQ);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t             state_reg, state_next;
    logic [N_REQ-1:0]   gnt_reg, gnt_next;
    logic               busy_reg;
    logic [OWNER_W-1:0] owner_reg, owner_next;
    logic [OWNER_W-1:0] last_owner_reg, last_owner_next;
    logic [HOLD_W-1:0]  hold_reg, hold_next;
    logic [TURN_W-1:0]  turn_reg, turn_next;
    logic [N_REQ-1:0]   mask_reg, mask_next;
    logic               timeout_reg;
    logic [OWNER_W-1:0] timeout_id_reg, timeout_id_next;
    logic [7:0]         timeout_cnt_reg, timeout_cnt_next;

    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   win_onehot;
    logic [OWNER_W-1:0] win_idx;
    logic               win_found;
    logic [OWNER_W:0]   cand_sum;
    logic               arb_now;
    logic               timeout_evt;

    // A timed-out requester stays masked until it lets go of REQ for a cycle.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign eligible[gi]   = ENABLE_I & REQ_I[gi] & ~mask_reg[gi];
            assign win_onehot[gi] = (win_idx == OWNER_W'(gi));
            assign mask_next[gi]  = REQ_I[gi] &
                                    (mask_reg[gi] | (timeout_evt & (owner_reg == OWNER_W'(gi))));
        end
    endgenerate

    // Scan from farthest to nearest offset so the nearest eligible index after last_owner wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand_sum = {1'b0, last_owner_reg} + (OWNER_W + 1)'(off);
            if (cand_sum >= N_REQ_EXT) begin
                cand_sum = cand_sum - N_REQ_EXT;
            end
            if (eligible[cand_sum[OWNER_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand_sum[OWNER_W-1:0];
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        gnt_next        = gnt_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        hold_next       = hold_reg;
        turn_next       = turn_reg;
        timeout_evt     = 1'b0;
        arb_now         = 1'b0;

        case (state_reg)
            IDLE: begin
                arb_now = 1'b1;
            end
            GRANT: begin
                // A release on the same edge as the hold limit counts as a release.
                if (!REQ_I[owner_reg]) begin
                    gnt_next   = '0;
                    turn_next  = '0;
                    state_next = TURN;
                end else if (hold_reg == HOLD_LAST) begin
                    gnt_next    = '0;
                    turn_next   = '0;
                    timeout_evt = 1'b1;
                    state_next  = TURN;
                end else begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            TURN: begin
                if (turn_reg == TURN_LAST) begin
                    arb_now    = 1'b1;
                    state_next = IDLE;
                end else begin
                    turn_next = turn_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase

        if (arb_now && win_found) begin
            gnt_next        = win_onehot;
            owner_next      = win_idx;
            last_owner_next = win_idx;
            hold_next       = '0;
            state_next      = GRANT;
        end
    end

    always_comb begin
        timeout_id_next  = timeout_evt ? owner_reg : timeout_id_reg;
        timeout_cnt_next = timeout_cnt_reg;
        if (CLR_STATS_I) begin
            timeout_cnt_next = '0;
        end else if (timeout_evt && (timeout_cnt_reg != 8'hFF)) begin
            timeout_cnt_next = timeout_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge PHY_CLK33_I or negedge PHY_RSTn_I) begin
        if (!PHY_RSTn_I) begin
            state_reg       <= IDLE;
            gnt_reg         <= '0;
            busy_reg        <= 1'b0;
            owner_reg       <= '0;
            last_owner_reg  <= OWNER_W'(N_REQ - 1);
            hold_reg        <= '0;
            turn_reg        <= '0;
            mask_reg        <= '0;
            timeout_reg     <= 1'b0;
            timeout_id_reg  <= '0;
            timeout_cnt_reg <= '0;
        end else begin
            state_reg       <= state_next;
            gnt_reg         <= gnt_next;
            busy_reg        <= |gnt_next;
            owner_reg       <= owner_next;
            last_owner_reg  <= last_owner_next;
            hold_reg        <= hold_next;
            turn_reg        <= turn_next;
            mask_reg        <= mask_next;
            timeout_reg     <= timeout_evt;
            timeout_id_reg  <= timeout_id_next;
            timeout_cnt_reg <= timeout_cnt_next;
        end
    end

    assign GNT_O         = gnt_reg;
    assign BUS_BUSY_O    = busy_reg;
    assign OWNER_O       = owner_reg;
    assign TIMEOUT_O     = timeout_reg;
    assign TIMEOUT_ID_O  = timeout_id_reg;
    assign TIMEOUT_CNT_O = timeout_cnt_reg;

endmodule
